job_sequencer: RTL

JOB_SEQUENCER -- requirements
Module: job_sequencer

---
 rtl/job_sequencer_if.sv | 26 ++
 rtl/job_sequencer.sv | 82 ++++++++
 2 files changed

// File: rtl/job_sequencer_if.sv
// job_sequencer_if: job control, shapool round reporting and host result handshake bundle.
interface job_sequencer_if #(
  parameter int N_CORES     = 8,
  parameter int NONCE_WIDTH = 32
);
  logic                   job_load;
  logic                   core_reset_n;
  logic                   round_done;
  logic [N_CORES-1:0]     match_flags;
  logic [NONCE_WIDTH-1:0] nonce;
  logic                   result_valid;
  logic [N_CORES-1:0]     result_flags;
  logic [NONCE_WIDTH-1:0] result_nonce;
  logic                   exhausted;
  logic                   result_ack;
  logic                   busy;
  logic [31:0]            round_count;
  modport master (
    output job_load, round_done, match_flags, nonce, result_ack,
    input  core_reset_n, result_valid, result_flags, result_nonce, exhausted, busy, round_count
  );
  modport slave (
    input  job_load, round_done, match_flags, nonce, result_ack,
    output core_reset_n, result_valid, result_flags, result_nonce, exhausted, busy, round_count
  );
endinterface

// File: rtl/job_sequencer.sv
// job_sequencer: warms up the shapool cores, runs rounds until a match or nonce exhaustion, holds the outcome for the host.
// Optional ROUND_COUNTER_EN adds a saturating per-job round counter; otherwise round_count is tied to 0.
module job_sequencer #(
  parameter int N_CORES       = 8,
  parameter int NONCE_WIDTH   = 32,
  parameter int WARMUP_CYCLES = 4
) (
  input logic             clk,
  input logic             reset_n,
  job_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, WARMUP, RUN, FOUND, EXHAUSTED} state_t;
  localparam logic [7:0] WLOAD = 8'(WARMUP_CYCLES - 1);
  state_t                 r_state, w_next;
  logic [7:0]             r_wcnt, w_wcnt;
  logic                   w_accept, w_found, w_abort;
  logic                   r_core_reset_n, r_busy, r_result_valid, r_exhausted;
  logic [N_CORES-1:0]     r_result_flags;
  logic [NONCE_WIDTH-1:0] r_result_nonce;
  assign w_accept = r_state == RUN && bus.round_done && !bus.job_load;
  assign w_found  = w_accept && |bus.match_flags;
  assign w_abort  = bus.job_load && (r_state == WARMUP || r_state == RUN);
  always_comb begin
    w_next = r_state;
    w_wcnt = r_wcnt;
    if (bus.job_load) begin
      w_next = WARMUP;
      w_wcnt = WLOAD;
    end else begin
      case (r_state)
        WARMUP: begin
          w_next = r_wcnt == 8'd0 ? RUN : WARMUP;
          w_wcnt = r_wcnt == 8'd0 ? r_wcnt : r_wcnt - 8'd1;
        end
        RUN:             w_next = w_found ? FOUND : (w_accept && &bus.nonce) ? EXHAUSTED : RUN;
        FOUND, EXHAUSTED: w_next = bus.result_ack ? IDLE : r_state;
        default:         w_next = r_state;
      endcase
    end
  end
  // an abort out of WARMUP/RUN drops core_reset_n for the first cycle of the restarted warmup
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_wcnt         <= 8'd0;
      r_core_reset_n <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_exhausted    <= 1'b0;
      r_result_flags <= '0;
      r_result_nonce <= '0;
    end else begin
      r_state        <= w_next;
      r_wcnt         <= w_wcnt;
      r_core_reset_n <= (w_next == WARMUP || w_next == RUN) && !w_abort;
      r_busy         <= w_next == WARMUP || w_next == RUN;
      r_result_valid <= w_next == FOUND;
      r_exhausted    <= w_next == EXHAUSTED;
      if (w_found) begin
        r_result_flags <= bus.match_flags;
        r_result_nonce <= bus.nonce;
      end
    end
  end
  assign bus.core_reset_n = r_core_reset_n;
  assign bus.busy         = r_busy;
  assign bus.result_valid = r_result_valid;
  assign bus.exhausted    = r_exhausted;
  assign bus.result_flags = r_result_flags;
  assign bus.result_nonce = r_result_nonce;
`ifdef ROUND_COUNTER_EN
  logic [31:0] r_round_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_round_count <= 32'd0;
    else if (bus.job_load) r_round_count <= 32'd0;
    else if (w_accept && r_round_count != 32'hFFFF_FFFF) r_round_count <= r_round_count + 32'd1;
  end
  assign bus.round_count = r_round_count;
`else
  assign bus.round_count = 32'd0;
`endif
endmodule
